// File: rtl/gcd_pkg.sv
// Shared constants for the GCD engine: algorithm selectors and FSM state encoding.
package gcd_pkg;

  localparam int MODE_SUB = 0;
  localparam int MODE_BIN = 1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration: termination test, then a subtractive or binary (Stein) reduction step.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = MODE_SUB,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [KW-1:0]    k_o,
  output logic             finish_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] base;

  always_comb begin
    x_o      = x_i;
    y_o      = y_i;
    k_o      = k_i;
    finish_o = 1'b0;
    base     = '0;
    if (x_i == '0) begin
      finish_o = 1'b1;
      base     = y_i;
    end else if (y_i == '0 || x_i == y_i) begin
      finish_o = 1'b1;
      base     = x_i;
    end else if (MODE == MODE_SUB) begin
      if (x_i > y_i) x_o = x_i - y_i;
      else           y_o = y_i - x_i;
    end else begin
      // common factors of two are stripped into k and restored on the result
      if (!x_i[0] && !y_i[0]) begin
        x_o = x_i >> 1;
        y_o = y_i >> 1;
        k_o = k_i + KW'(1);
      end else if (!x_i[0]) begin
        x_o = x_i >> 1;
      end else if (!y_i[0]) begin
        y_o = y_i >> 1;
      end else if (x_i > y_i) begin
        x_o = (x_i - y_i) >> 1;
      end else begin
        y_o = (y_i - x_i) >> 1;
      end
    end
    result_o = (MODE == MODE_BIN) ? (base << k_i) : base;
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with an ap_start/ap_done handshake; one reduction step per CALC cycle.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = MODE_SUB
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic [WIDTH-1:0] ap_return,
  output logic [WIDTH-1:0] iter_cnt
);

  // state  | meaning
  // IDLE   | waiting for ap_start, operands sampled on acceptance
  // CALC   | one reduction step per cycle until termination
  // DONE   | single-cycle ap_done pulse, results valid

  localparam int KW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] ret_q, ret_d, iter_q, iter_d;

  logic [WIDTH-1:0] step_x, step_y, step_res;
  logic [KW-1:0]    step_k;
  logic             step_fin;

  gcd_step #(.WIDTH(WIDTH), .MODE(MODE), .KW(KW)) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .k_i      (k_q),
    .x_o      (step_x),
    .y_o      (step_y),
    .k_o      (step_k),
    .finish_o (step_fin),
    .result_o (step_res)
  );

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
  assign ap_idle   = (state_q == S_IDLE);
  assign ap_ready  = (state_q == S_IDLE) && ap_start && ap_rst_n;
  assign ap_done   = (state_q == S_DONE);
  assign ap_return = ret_q;
  assign iter_cnt  = iter_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          x_d     = a;
          y_d     = b;
          k_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        x_d   = step_x;
        y_d   = step_y;
        k_d   = step_k;
        cnt_d = cnt_inc;
        if (step_fin) begin
          ret_d   = step_res;
          iter_d  = cnt_inc;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: subtractive and binary instances side by side, scoreboarded results.
module tb_gcd_engine;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start_s = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;

  logic        idle_s, rdy_s, done_s, idle_b, rdy_b, done_b;
  logic [31:0] ret_s, iter_s, ret_b, iter_b;

  int          cyc      = 0;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] q_s[$];
  logic [31:0] q_b[$];
  int          dcyc_s = -1;
  int          dcyc_b = -1;
  logic [31:0] diter_s = '0;
  logic [31:0] diter_b = '0;
  bit          prev_rdy_s = 1'b0;
  bit          prev_rdy_b = 1'b0;

  logic [31:0] ta[8] = '{32'd12, 32'd5, 32'd7, 32'd0, 32'd8, 32'd27, 32'd14, 32'd1};
  logic [31:0] tb[8] = '{32'd18, 32'd0, 32'd7, 32'd3, 32'd12, 32'd9, 32'd35, 32'd1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_engine #(.WIDTH(32), .MODE(0)) u_sub (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_s), .a(a), .b(b),
    .ap_idle(idle_s), .ap_ready(rdy_s), .ap_done(done_s),
    .ap_return(ret_s), .iter_cnt(iter_s)
  );

  gcd_engine #(.WIDTH(32), .MODE(1)) u_bin (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_b), .a(a), .b(b),
    .ap_idle(idle_b), .ap_ready(rdy_b), .ap_done(done_b),
    .ap_return(ret_b), .iter_cnt(iter_b)
  );

  function automatic logic [31:0] ref_gcd(input logic [31:0] x0, input logic [31:0] y0);
    logic [31:0] x, y, t;
    x = x0;
    y = y0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboards: expected result pushed on acceptance, popped on ap_done
  always @(negedge clk) begin
    if (!rst_n) begin
      q_s.delete();
    end else begin
      chk("sub_ready_vs_idle", rdy_s, start_s & idle_s);
      if (prev_rdy_s) chk("sub_idle_after_accept", idle_s, 1'b0);
      if (rdy_s) q_s.push_back(ref_gcd(a, b));
      if (done_s) begin
        if (q_s.size() == 0) chk("sub_unexpected_done", done_s, 1'b0);
        else                 chk("sub_return", ret_s, q_s.pop_front());
        dcyc_s  = cyc;
        diter_s = iter_s;
      end
    end
    prev_rdy_s = rdy_s & rst_n;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q_b.delete();
    end else begin
      chk("bin_ready_vs_idle", rdy_b, start_b & idle_b);
      if (prev_rdy_b) chk("bin_idle_after_accept", idle_b, 1'b0);
      if (rdy_b) q_b.push_back(ref_gcd(a, b));
      if (done_b) begin
        if (q_b.size() == 0) chk("bin_unexpected_done", done_b, 1'b0);
        else                 chk("bin_return", ret_b, q_b.pop_front());
        dcyc_b  = cyc;
        diter_b = iter_b;
      end
    end
    prev_rdy_b = rdy_b & rst_n;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sub_idle"}, idle_s, 1'b1);
    chk({tag, "_sub_done"}, done_s, 1'b0);
    chk({tag, "_sub_return"}, ret_s, 32'd0);
    chk({tag, "_sub_iter"}, iter_s, 32'd0);
    chk({tag, "_bin_idle"}, idle_b, 1'b1);
    chk({tag, "_bin_done"}, done_b, 1'b0);
    chk({tag, "_bin_return"}, ret_b, 32'd0);
    chk({tag, "_bin_iter"}, iter_b, 32'd0);
  endtask

  task automatic wait_done(input bit gs, input bit gb);
    for (int i = 0; i < 400 && ((gs && dcyc_s < 0) || (gb && dcyc_b < 0)); i++)
      @(posedge clk);
    if (gs) chk("sub_done_seen", dcyc_s >= 0, 1'b1);
    if (gb) chk("bin_done_seen", dcyc_b >= 0, 1'b1);
  endtask

  // negative ls/is/lb/ib skip that latency or iteration check
  task automatic run(input logic [31:0] av, input logic [31:0] bv, input bit gs, input bit gb,
                     input int ls, input int is, input int lb, input int ib);
    int n;
    @(posedge clk); #1;
    a = av; b = bv; start_s = gs; start_b = gb;
    dcyc_s = -1; dcyc_b = -1; n = cyc;
    @(posedge clk); #1;
    start_s = 1'b0; start_b = 1'b0;
    wait_done(gs, gb);
    if (gs && ls >= 0) chk("sub_latency", dcyc_s - n, ls);
    if (gs && is >= 0) chk("sub_iter", diter_s, is);
    if (gb && lb >= 0) chk("bin_latency", dcyc_b - n, lb);
    if (gb && ib >= 0) chk("bin_iter", diter_b, ib);
  endtask

  initial begin
    int n2;
    start_s = 1'b1;
    start_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_sub_ready", rdy_s, 1'b0);
    chk("reset_bin_ready", rdy_b, 1'b0);
    @(posedge clk); #1;
    start_s = 1'b0; start_b = 1'b0; rst_n = 1'b1;

    run(32'd12, 32'd18, 1, 1, 4, 3, 5, 4);
    run(32'd0,  32'd7,  1, 1, 2, 1, 2, 1);
    run(32'd9,  32'd0,  1, 1, 2, 1, 2, 1);
    run(32'd0,  32'd0,  1, 1, 2, 1, 2, 1);
    run(32'd35, 32'd21, 1, 1, 5, 4, 4, 3);
    run(32'd48, 32'd36, 1, 1, -1, -1, -1, -1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, -1, -1, -1, -1);
    chk("bin_iter_bound", diter_b <= 32'd66, 1'b1);

    // ap_start held high while operands change every cycle
    @(posedge clk); #1;
    start_s = 1'b1; start_b = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = ta[i % 8];
      b = tb[i % 8];
      @(posedge clk); #1;
    end
    start_s = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 400 && (q_s.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
    chk("stream_drained", q_s.size() + q_b.size(), 0);

    // reset pulse mid-computation, then a start in the first cycle after release
    @(posedge clk); #1;
    a = 32'd12; b = 32'd18; start_s = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0; start_b = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; a = 32'd35; b = 32'd21; start_s = 1'b1; start_b = 1'b1;
    dcyc_s = -1; dcyc_b = -1; n2 = cyc;
    @(negedge clk);
    check_reset_outputs("abort");
    chk("abort_sub_accept", rdy_s, 1'b1);
    chk("abort_bin_accept", rdy_b, 1'b1);
    @(posedge clk); #1;
    start_s = 1'b0; start_b = 1'b0;
    wait_done(1, 1);
    chk("abort_sub_latency", dcyc_s - n2, 5);
    chk("abort_bin_latency", dcyc_b - n2, 4);
    chk("abort_sub_iter", diter_s, 4);
    chk("abort_bin_iter", diter_b, 3);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
